oneway_frame_receiver: RTL and testbench

- Parametrised successor to the inter-board one-way receiver.
- Takes a LANES-wide parallel data bus, a beat strobe (packet_pulse) and a frame-commit strobe (transmit_ctrl) from another board, and reassembles them into a MESSAGE_SIZE-bit message.
- All inputs are synchronised, debounced and edge-detected inside one clock domain; no input is ever used as a clock.
- Adds beat counting, frame-length checking, a valid pulse and an error pulse. Sits at the board-link boundary and feeds game-state decode.

---
 rtl/oneway_frame_receiver.sv | 108 ++++++++++
 tb/tb_oneway_frame_receiver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/oneway_frame_receiver.sv
// Reassembles LANES-wide beats from an asynchronous board link into MESSAGE_SIZE-bit messages.
// Raw edge to rise takes about SYNC_STAGES+DB_CYCLES+1 cycles, commit adds 2; there is no backpressure.
module oneway_frame_receiver #(
    parameter int MESSAGE_SIZE = 100,
    parameter int LANES        = 6,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CYCLES    = 4
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic [LANES-1:0]                                         din,
    input  logic                                                     packet_pulse,
    input  logic                                                     transmit_ctrl,
    output logic [MESSAGE_SIZE-1:0]                                  read_buffer,
    output logic                                                     msg_valid,
    output logic                                                     frame_err,
    output logic [$clog2(((MESSAGE_SIZE+LANES-1)/LANES)+2)-1:0]      beat_count
);
    localparam int BEATS = (MESSAGE_SIZE + LANES - 1) / LANES;
    localparam int BUF_W = BEATS * LANES;
    localparam int NSIG  = LANES + 2;
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam int BC_W  = $clog2(BEATS + 2);

    logic [NSIG-1:0]  r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_db_cnt [NSIG];
    logic [NSIG-1:0]  r_filt;
    logic [NSIG-1:0]  r_filt_d;
    logic [BUF_W-1:0] r_buf;
    logic             r_commit;

    logic [NSIG-1:0]  w_raw;
    logic [NSIG-1:0]  w_sync;
    logic [NSIG-1:0]  w_rise;
    logic [LANES-1:0] w_din;
    logic             w_pkt_rise;
    logic             w_ctrl_rise;

    assign w_raw       = {transmit_ctrl, packet_pulse, din};
    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_rise      = r_filt & ~r_filt_d;
    assign w_din       = r_filt[LANES-1:0];
    assign w_pkt_rise  = w_rise[LANES];
    assign w_ctrl_rise = w_rise[LANES+1];

    // Every input, data lanes included, gets the same sync + debounce treatment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            for (int i = 0; i < NSIG; i++) r_db_cnt[i] <= '0;
            r_filt   <= '0;
            r_filt_d <= '0;
        end else begin
            r_sync[0] <= w_raw;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_filt_d <= r_filt;
            for (int i = 0; i < NSIG; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    r_filt[i]   <= w_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Commit is judged one cycle after the ctrl rise so a beat arriving with it is counted first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf       <= '0;
            r_commit    <= 1'b0;
            beat_count  <= '0;
            read_buffer <= '0;
            msg_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            frame_err <= 1'b0;
            r_commit  <= w_ctrl_rise;
            if (w_pkt_rise) begin
                r_buf <= {w_din, r_buf[BUF_W-1:LANES]};
            end
            if (r_commit) begin
                if (beat_count == BC_W'(BEATS)) begin
                    read_buffer <= r_buf[BUF_W-1 -: MESSAGE_SIZE];
                    msg_valid   <= 1'b1;
                end else begin
                    frame_err   <= 1'b1;
                end
                beat_count <= w_pkt_rise ? BC_W'(1) : '0;
            end else if (w_pkt_rise && (beat_count != BC_W'(BEATS + 1))) begin
                beat_count <= beat_count + BC_W'(1);
            end
        end
    end

    // Low bits of the first beat fall below the delivered window when LANES does not divide MESSAGE_SIZE.
    generate
        if (BUF_W > MESSAGE_SIZE) begin : g_pad
            logic w_unused_pad;
            assign w_unused_pad = ^r_buf[BUF_W-MESSAGE_SIZE-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_oneway_frame_receiver.sv
// Directed bench for oneway_frame_receiver at default parameters.
module tb_oneway_frame_receiver;
    localparam int MS    = 100;
    localparam int LN    = 6;
    localparam int BEATS = 17;

    logic          clk;
    logic          rst;
    logic [LN-1:0] din;
    logic          packet_pulse;
    logic          transmit_ctrl;
    logic [MS-1:0] read_buffer;
    logic          msg_valid;
    logic          frame_err;
    logic [4:0]    beat_count;

    oneway_frame_receiver #(.MESSAGE_SIZE(MS), .LANES(LN), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .packet_pulse (packet_pulse),
        .transmit_ctrl(transmit_ctrl),
        .read_buffer  (read_buffer),
        .msg_valid    (msg_valid),
        .frame_err    (frame_err),
        .beat_count   (beat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_valid = 0;
    int cnt_err   = 0;
    int cnt_both  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (msg_valid) cnt_valid++;
            if (frame_err) cnt_err++;
            if (msg_valid && frame_err) cnt_both++;
        end
    end

    typedef struct {
        int nbeats;
        int base;
        bit simul;
        bit exp_valid;
    } frame_vec_t;

    frame_vec_t    vecs [6];
    logic [MS-1:0] exp_rb;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [MS-1:0] payload(input int base);
        logic [BEATS*LN-1:0] full;
        logic [LN-1:0]       v;
        full = '0;
        for (int k = 0; k < BEATS; k++) begin
            v = LN'(base + k);
            full[LN*k +: LN] = v;
        end
        return full[BEATS*LN-1 -: MS];
    endfunction

    task automatic send_beat(input logic [LN-1:0] v);
        din = v;
        tick(8);
        packet_pulse = 1'b1;
        tick(10);
        packet_pulse = 1'b0;
        tick(10);
    endtask

    task automatic send_ctrl();
        transmit_ctrl = 1'b1;
        tick(10);
        transmit_ctrl = 1'b0;
        tick(12);
    endtask

    task automatic run_frame(input int idx, input frame_vec_t fv);
        int vc0;
        int ec0;
        int exp_cnt;
        vc0 = cnt_valid;
        ec0 = cnt_err;
        for (int k = 0; k < fv.nbeats; k++) begin
            if (!(fv.simul && k == fv.nbeats - 1)) send_beat(LN'(fv.base + k));
        end
        if (fv.simul) begin
            check($sformatf("f%0d count_pre", idx), 128'(beat_count), 128'(fv.nbeats - 1));
            din = LN'(fv.base + fv.nbeats - 1);
            tick(8);
            packet_pulse  = 1'b1;
            transmit_ctrl = 1'b1;
            tick(10);
            packet_pulse  = 1'b0;
            transmit_ctrl = 1'b0;
            tick(12);
        end else begin
            exp_cnt = (fv.nbeats > BEATS + 1) ? BEATS + 1 : fv.nbeats;
            check($sformatf("f%0d count_pre", idx), 128'(beat_count), 128'(exp_cnt));
            send_ctrl();
        end
        if (fv.exp_valid) exp_rb = payload(fv.base);
        check($sformatf("f%0d valid_pulses", idx), 128'(cnt_valid - vc0), 128'(fv.exp_valid ? 1 : 0));
        check($sformatf("f%0d err_pulses", idx), 128'(cnt_err - ec0), 128'(fv.exp_valid ? 0 : 1));
        check($sformatf("f%0d count_post", idx), 128'(beat_count), 128'(0));
        check($sformatf("f%0d read_buffer", idx), 128'(read_buffer), 128'(exp_rb));
    endtask

    initial begin
        int vc0;
        int ec0;
        rst           = 1'b1;
        din           = '0;
        packet_pulse  = 1'b0;
        transmit_ctrl = 1'b0;
        exp_rb        = '0;

        vecs[0] = '{17, 0,  1'b0, 1'b1};
        vecs[1] = '{16, 20, 1'b0, 1'b0};
        vecs[2] = '{18, 5,  1'b0, 1'b0};
        vecs[3] = '{0,  0,  1'b0, 1'b0};
        vecs[4] = '{17, 33, 1'b0, 1'b1};
        vecs[5] = '{17, 40, 1'b1, 1'b1};

        tick(3);
        check("rst read_buffer", 128'(read_buffer), 128'(0));
        check("rst beat_count", 128'(beat_count), 128'(0));
        check("rst msg_valid", 128'(msg_valid), 128'(0));
        check("rst frame_err", 128'(frame_err), 128'(0));
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

        // Pulses one cycle short of the debounce window must vanish.
        vc0 = cnt_valid;
        ec0 = cnt_err;
        packet_pulse = 1'b1;
        tick(3);
        packet_pulse = 1'b0;
        tick(15);
        check("glitch pkt count", 128'(beat_count), 128'(0));
        transmit_ctrl = 1'b1;
        tick(3);
        transmit_ctrl = 1'b0;
        tick(15);
        check("glitch ctrl valid", 128'(cnt_valid - vc0), 128'(0));
        check("glitch ctrl err", 128'(cnt_err - ec0), 128'(0));
        check("glitch read_buffer", 128'(read_buffer), 128'(exp_rb));
        din = 6'h2a;
        tick(8);
        packet_pulse = 1'b1;
        tick(4);
        packet_pulse = 1'b0;
        tick(15);
        check("4cyc pkt count", 128'(beat_count), 128'(1));
        send_ctrl();
        check("4cyc frame err", 128'(cnt_err - ec0), 128'(1));
        check("4cyc count_post", 128'(beat_count), 128'(0));

        // Asynchronous reset in the middle of a frame.
        for (int k = 0; k < 9; k++) send_beat(LN'(7 + k));
        check("mid count", 128'(beat_count), 128'(9));
        #3 rst = 1'b1;
        #1;
        check("async rst read_buffer", 128'(read_buffer), 128'(0));
        check("async rst beat_count", 128'(beat_count), 128'(0));
        check("async rst msg_valid", 128'(msg_valid), 128'(0));
        check("async rst frame_err", 128'(frame_err), 128'(0));
        exp_rb = '0;
        tick(3);
        rst = 1'b0;
        tick(10);
        run_frame(6, '{17, 50, 1'b0, 1'b1});

        check("valid/err exclusive", 128'(cnt_both), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
